// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU-class decoder feeding a 2-entry issue FIFO.
// Define ALU_ISSUE_BRANCH_EN to also decode conditional branches.
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic [15:0]              issue_count
);
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       is_r;
    logic       is_i;
    logic       is_shift;
    logic       unused_bits;

    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_z;

    logic [OPCODE_LENGTH-1:0] ar_op;
    logic                     ar_ok;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_ok;
    logic [DATA_WIDTH-1:0]    dec_b;

    logic [DATA_WIDTH-1:0]    ent_a;
    logic [DATA_WIDTH-1:0]    ent_b;
    logic [OPCODE_LENGTH-1:0] ent_op;
    logic                     ent_ill;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign is_r        = (opcode == OPC_R);
    assign is_i        = (opcode == OPC_I);
    assign is_shift    = (funct3[1:0] == 2'b01);
    assign unused_bits = ^{instr[19:15], instr[11:7]};

    assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_z = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};

    // Shared R/I arithmetic table; funct7 only qualifies ADD/SUB on R-type.
    always_comb begin
        ar_op = OP_ILL;
        ar_ok = 1'b1;
        case (funct3)
            3'b000: begin
                if (is_r && funct7 == F7_ALT) ar_op = OP_SUB;
                else if (!is_r || funct7 == F7_BASE) ar_op = OP_ADD;
                else ar_ok = 1'b0;
            end
            3'b001: ar_op = OP_SLL;
            3'b010: ar_op = OP_SLT;
            3'b100: ar_op = OP_XOR;
            3'b101: begin
                if (funct7 == F7_BASE) ar_op = OP_SRL;
                else if (funct7 == F7_ALT) ar_op = OP_SRA;
                else ar_ok = 1'b0;
            end
            3'b110: ar_op = OP_OR;
            3'b111: ar_op = OP_AND;
            default: ar_ok = 1'b0;
        endcase
    end

`ifdef ALU_ISSUE_BRANCH_EN
    localparam logic [6:0] OPC_B = 7'b1100011;
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_BLT = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] OP_BGE = OPCODE_LENGTH'(4'b1100);

    logic                     is_b;
    logic [OPCODE_LENGTH-1:0] br_op;
    logic                     br_ok;

    assign is_b = (opcode == OPC_B);

    always_comb begin
        br_op = OP_ILL;
        br_ok = 1'b1;
        case (funct3)
            3'b000:  br_op = OP_BEQ;
            3'b001:  br_op = OP_BNE;
            3'b100:  br_op = OP_BLT;
            3'b101:  br_op = OP_BGE;
            default: br_ok = 1'b0;
        endcase
    end
`endif

    always_comb begin
        dec_ok = 1'b0;
        dec_op = ar_op;
        dec_b  = rs2_data;
        unique case (1'b1)
            is_r: dec_ok = ar_ok;
            is_i: begin
                dec_ok = ar_ok;
                dec_b  = is_shift ? imm_z : imm_s;
            end
`ifdef ALU_ISSUE_BRANCH_EN
            is_b: begin
                dec_ok = br_ok;
                dec_op = br_op;
            end
`endif
            default: dec_ok = 1'b0;
        endcase
    end

    assign ent_a   = dec_ok ? rs1_data : '0;
    assign ent_b   = dec_ok ? dec_b : '0;
    assign ent_op  = dec_ok ? dec_op : OP_ILL;
    assign ent_ill = !dec_ok;

    logic [1:0]               count;
    logic                     push;
    logic                     pop;
    logic                     head_from_in;
    logic                     head_from_tail;
    logic                     tail_load;
    logic [DATA_WIDTH-1:0]    tail_a;
    logic [DATA_WIDTH-1:0]    tail_b;
    logic [OPCODE_LENGTH-1:0] tail_op;
    logic                     tail_ill;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The head register is the only output source; the tail backs it up.
    assign head_from_in   = !flush && push &&
                            (count == 2'd0 || (count == 2'd1 && pop));
    assign head_from_tail = !flush && pop && count == 2'd2;
    assign tail_load      = !flush && push && count == 2'd1 && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= 2'd0;
            issue_count <= 16'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop) issue_count <= issue_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            SrcA      <= '0;
            SrcB      <= '0;
            Operation <= '0;
            illegal   <= 1'b0;
        end else if (head_from_in) begin
            SrcA      <= ent_a;
            SrcB      <= ent_b;
            Operation <= ent_op;
            illegal   <= ent_ill;
        end else if (head_from_tail) begin
            SrcA      <= tail_a;
            SrcB      <= tail_b;
            Operation <= tail_op;
            illegal   <= tail_ill;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tail_a   <= '0;
            tail_b   <= '0;
            tail_op  <= '0;
            tail_ill <= 1'b0;
        end else if (tail_load) begin
            tail_a   <= ent_a;
            tail_b   <= ent_b;
            tail_op  <= ent_op;
            tail_ill <= ent_ill;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vector table plus hand-written FIFO sequences.
// Build with or without ALU_ISSUE_BRANCH_EN; expectations follow the macro.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic        illegal;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic [15:0] issue_count;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .illegal(illegal), .issue_count(issue_count)
    );

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rt(input logic [6:0] f7,
                                       input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] it(input logic [11:0] imm,
                                       input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    function automatic logic [31:0] bt(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    task automatic add(input string n, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic ill,
                       input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.name = n; v.ins = ins; v.a = a; v.b = b;
        v.op = op; v.ill = ill; v.ea = ea; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic ill_vec(input string n, input logic [31:0] ins);
        add(n, ins, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'hF, 1'b1, 0, 0);
    endtask

    task automatic head(input string n, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        chk({n, ".op"}, {28'd0, Operation}, {28'd0, op});
        chk({n, ".a"}, SrcA, a);
        chk({n, ".b"}, SrcB, b);
    endtask

    localparam logic [31:0] A = 32'h1234_5678;
    localparam logic [31:0] B = 32'h0F0F_0F0F;

    initial begin
        add("add", rt(7'h00, 3'b000), 5, 7, 4'b0010, 0, 5, 7);
        add("sub", rt(7'h20, 3'b000), A, B, 4'b0011, 0, A, B);
        add("and", rt(7'h00, 3'b111), A, B, 4'b0000, 0, A, B);
        add("or", rt(7'h00, 3'b110), A, B, 4'b0001, 0, A, B);
        add("xor", rt(7'h00, 3'b100), A, B, 4'b0100, 0, A, B);
        add("slt", rt(7'h00, 3'b010), A, B, 4'b1001, 0, A, B);
        add("sll", rt(7'h00, 3'b001), A, B, 4'b0110, 0, A, B);
        add("srl", rt(7'h00, 3'b101), A, B, 4'b0111, 0, A, B);
        add("sra", rt(7'h20, 3'b101), A, B, 4'b0101, 0, A, B);
        ill_vec("r_f7bad", rt(7'h01, 3'b101));
        ill_vec("r_add_f7bad", rt(7'h01, 3'b000));
        ill_vec("r_sltu", rt(7'h00, 3'b011));
        add("addi_m1", it(12'hFFF, 3'b000), A, B, 4'b0010, 0, A,
            32'hFFFF_FFFF);
        add("addi_max", it(12'h7FF, 3'b000), A, B, 4'b0010, 0, A,
            32'h0000_07FF);
        add("addi_f7", it(12'h400, 3'b000), A, B, 4'b0010, 0, A,
            32'h0000_0400);
        add("andi", it(12'h800, 3'b111), A, B, 4'b0000, 0, A,
            32'hFFFF_F800);
        add("slli", it(12'h005, 3'b001), A, B, 4'b0110, 0, A, 5);
        add("srai", it(12'h403, 3'b101), A, B, 4'b0101, 0, A, 3);
        add("srli", it(12'h01F, 3'b101), A, B, 4'b0111, 0, A, 31);
        ill_vec("i_f7bad", it(12'h023, 3'b101));
        ill_vec("i_sltiu", it(12'h001, 3'b011));
        ill_vec("lui", 32'h0001_20B7);
`ifdef ALU_ISSUE_BRANCH_EN
        add("beq", bt(3'b000), A, B, 4'b1000, 0, A, B);
        add("bne", bt(3'b001), A, B, 4'b1010, 0, A, B);
        add("blt", bt(3'b100), A, B, 4'b1011, 0, A, B);
        add("bge", bt(3'b101), A, B, 4'b1100, 0, A, B);
        ill_vec("bltu", bt(3'b110));
`else
        ill_vec("beq", bt(3'b000));
        ill_vec("bne", bt(3'b001));
`endif

        // Asynchronous reset, before any clock edge.
        #1 reset = 1'b1;
        #2;
        chk("rst.out_valid", {31'd0, out_valid}, 0);
        chk("rst.cnt", {16'd0, issue_count}, 0);
        chk("rst.ill", {31'd0, illegal}, 0);
        head("rst", 4'h0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst.in_ready", {31'd0, in_ready}, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr = vecs[i].ins;
            rs1_data = vecs[i].a;
            rs2_data = vecs[i].b;
            @(negedge clk);
            in_valid = 1'b0;
            chk({vecs[i].name, ".valid"}, {31'd0, out_valid}, 1);
            chk({vecs[i].name, ".ill"}, {31'd0, illegal},
                {31'd0, vecs[i].ill});
            head(vecs[i].name, vecs[i].op, vecs[i].ea, vecs[i].eb);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            exp_cnt++;
            chk({vecs[i].name, ".drained"}, {31'd0, out_valid}, 0);
        end
        chk("vec.count", {16'd0, issue_count}, {16'd0, exp_cnt});

        // Back-to-back SRAI then ADDI, drained in order.
        in_valid = 1'b1; instr = it(12'h403, 3'b101); rs1_data = 1;
        @(negedge clk);
        instr = it(12'hFFF, 3'b000); rs1_data = 2;
        @(negedge clk);
        in_valid = 1'b0;
        head("b2b0", 4'b0101, 1, 3);
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        head("b2b1", 4'b0010, 2, 32'hFFFF_FFFF);
        @(negedge clk);
        exp_cnt++;
        out_ready = 1'b0;
        chk("b2b.empty", {31'd0, out_valid}, 0);

        // Three pushes against a stalled consumer.
        in_valid = 1'b1; instr = rt(7'h00, 3'b000);
        rs1_data = 32'h11; rs2_data = 32'h21;
        @(negedge clk);
        chk("full.rdy1", {31'd0, in_ready}, 1);
        rs1_data = 32'h12; rs2_data = 32'h22;
        @(negedge clk);
        chk("full.rdy2", {31'd0, in_ready}, 0);
        head("full.h", 4'b0010, 32'h11, 32'h21);
        rs1_data = 32'h13; rs2_data = 32'h23;
        @(negedge clk);
        chk("full.rdy3", {31'd0, in_ready}, 0);
        head("full.hold", 4'b0010, 32'h11, 32'h21);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        head("full.d1", 4'b0010, 32'h12, 32'h22);
        chk("full.rdy4", {31'd0, in_ready}, 1);
        @(negedge clk);
        exp_cnt++;
        out_ready = 1'b0;
        chk("full.empty", {31'd0, out_valid}, 0);

        // Push and pop together with one entry held.
        in_valid = 1'b1; instr = rt(7'h00, 3'b111);
        rs1_data = 32'h31; rs2_data = 32'h41;
        @(negedge clk);
        instr = rt(7'h00, 3'b110); rs1_data = 32'h32; rs2_data = 32'h42;
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        in_valid = 1'b0;
        chk("pp.valid", {31'd0, out_valid}, 1);
        chk("pp.rdy", {31'd0, in_ready}, 1);
        head("pp", 4'b0001, 32'h32, 32'h42);
        @(negedge clk);
        exp_cnt++;
        out_ready = 1'b0;
        chk("pp.count", {16'd0, issue_count}, {16'd0, exp_cnt});

        // Flush while full overrides both push and pop.
        in_valid = 1'b1; instr = rt(7'h00, 3'b000);
        repeat (2) @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush.valid", {31'd0, out_valid}, 0);
        chk("flush.rdy", {31'd0, in_ready}, 1);
        chk("flush.count", {16'd0, issue_count}, {16'd0, exp_cnt});

        // Reset while an entry is waiting to be popped.
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("mrst.valid", {31'd0, out_valid}, 0);
        chk("mrst.cnt", {16'd0, issue_count}, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 16'd0;
        #1;
        chk("mrst.cnt2", {16'd0, issue_count}, 0);
        chk("mrst.rdy", {31'd0, in_ready}, 1);
        chk("mrst.empty", {31'd0, out_valid}, 0);

        // Streaming push+pop until issue_count wraps.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (65536) @(negedge clk);
        chk("wrap.ffff", {16'd0, issue_count}, 32'h0000_FFFF);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("wrap.zero", {16'd0, issue_count}, 0);
        chk("wrap.empty", {31'd0, out_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the operand datapath.
REQ-002 Parameter OPCODE_LENGTH, default 4, width of the ALU operation code.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  the instruction and operands on the inputs are valid.
REQ-006 Port in_ready  output  1  the block can accept an input this cycle.
REQ-007 Port instr  input  32  RV32I instruction word.
REQ-008 Port rs1_data, rs2_data  input  DATA_WIDTH each  register-file read values.
REQ-009 Port flush  input  1  synchronous discard of all buffered entries.
REQ-010 Port out_valid  output  1  SrcA, SrcB, Operation and illegal are valid.
REQ-011 Port out_ready  input  1  the downstream ALU stage consumes the head entry.
REQ-012 Port SrcA, SrcB  output  DATA_WIDTH each  ALU operands.
REQ-013 Port Operation  output  OPCODE_LENGTH  ALU operation code.
REQ-014 Port illegal  output  1  the head entry is not an ALU-class instruction.
REQ-015 Port issue_count  output  16  number of entries popped since reset.

Function
REQ-016 Decode SHALL be combinational on input; result SHALL be stored in a 2-entry FIFO; outputs SHALL come from the FIFO head register only.
REQ-017 Opcode 0110011 (R-type) funct3/funct7 SHALL map as: 000/0000000->0010, 000/0100000->0011, 111->0000, 110->0001, 100->0100, 010->1001, 001->0110, 101/0000000->0111, 101/0100000->0101; SrcB=rs2_data.
REQ-018 Opcode 0010011 (I-type) SHALL use the same funct3 mapping (000 always 0010; 101 selected by instr[31:25]); SrcB = sign-extended instr[31:20] for non-shifts, zero-extended instr[24:20] for shifts.
REQ-019 SrcA SHALL equal rs1_data for every decoded class.
REQ-020 Any other opcode or unlisted funct3/funct7 combination SHALL store Operation=1111, illegal=1, SrcA=SrcB=0.
REQ-021 in_ready SHALL be 1 when the FIFO holds fewer than 2 entries; a push occurs when in_valid and in_ready.
REQ-022 A pop occurs when out_valid and out_ready; out_valid SHALL be 1 when the FIFO holds at least 1 entry.
REQ-023 An input accepted at edge N into an empty FIFO SHALL appear on the outputs after edge N (1-cycle latency).
REQ-024 A simultaneous push and pop with one entry held SHALL leave one entry, the new one at the head after the edge.
REQ-025 When full, in_ready=0; a pop frees a slot visible in the following cycle.
REQ-026 The head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 flush SHALL empty the FIFO at the next edge, overriding any push or pop that cycle; issue_count does not increment for a pop in a flush cycle.
REQ-028 issue_count SHALL increment by 1 per pop and wrap from FFFF to 0000.

Reset
REQ-029 While reset is high, asynchronously: FIFO empty, out_valid=0, SrcA=0, SrcB=0, Operation=0000, illegal=0, issue_count=0.
REQ-030 in_ready SHALL read 1 after reset deasserts; a reset asserted mid-transfer discards all entries with no pop counted.

Configuration
REQ-031 Macro ALU_ISSUE_BRANCH_EN defined: opcode 1100011 decodes funct3 000->1000, 001->1010, 100->1011, 101->1100, SrcB=rs2_data, illegal=0; other funct3 values are illegal.
REQ-032 Macro ALU_ISSUE_BRANCH_EN undefined: opcode 1100011 is illegal per REQ-020.

Verification
REQ-033 Reset, then push ADD x, rs1=5, rs2=7 with out_ready=1 -> next cycle out_valid=1, Operation=0010, SrcA=5, SrcB=7; issue_count=1 after the pop.
REQ-034 Push SRAI shamt=3 (instr[31:25]=0100000), then ADDI imm=FFF -> Operation=0101 with SrcB=3, then Operation=0010 with SrcB=FFFFFFFF.
REQ-035 out_ready=0, push 3 instructions back-to-back -> in_ready=0 after the second push, third not accepted, head unchanged; raise out_ready -> two entries drain in order.
REQ-036 FIFO full and flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, issue_count unchanged.
REQ-037 Push BNE (funct3 001) -> with ALU_ISSUE_BRANCH_EN: Operation=1010, illegal=0; without: Operation=1111, illegal=1.
REQ-038 Preload issue_count to FFFF via 65535 pops, then one more pop -> issue_count=0000.
